// File: rtl/rf_wb_writer.sv
// Writeback buffer and owner of the 32x32 register array: FIFO-queued writes, two combinational
// read ports, and a clear sequencer. Define RF_WB_BYPASS_EN to forward pending entries to reads.
module rf_wb_writer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     commit_en,
    input  logic                     clear_req,
    input  logic [ADDR_W-1:0]        Address1,
    input  logic [ADDR_W-1:0]        Address2,
    output logic [DATA_W-1:0]        Source1,
    output logic [DATA_W-1:0]        Source2,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   pending_cnt
);

    localparam int unsigned IW   = $clog2(DEPTH);
    localparam int unsigned PW   = IW + 1;
    localparam int unsigned NREG = 2 ** ADDR_W;

    typedef enum logic [1:0] {StInit, StRun, StDrain} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;

    logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
    logic [DATA_W-1:0] fifo_data_q [DEPTH];
    logic [DATA_W-1:0] regs_q [NREG];

    logic              empty, full, push, pop;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [DATA_W-1:0] arr_wdata;

    assign pending_cnt = wptr_q - rptr_q;
    assign empty       = (wptr_q == rptr_q);
    assign full        = (pending_cnt == PW'(DEPTH));
    assign wr_ready    = (state_q == StRun) && !full;
    assign busy        = (state_q != StRun);
    assign push        = wr_valid && wr_ready;
    assign pop         = (state_q != StInit) && commit_en && !empty;
    assign head_addr   = fifo_addr_q[rptr_q[IW-1:0]];
    assign head_data   = fifo_data_q[rptr_q[IW-1:0]];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wptr_d    = wptr_q + PW'(push);
        rptr_d    = rptr_q + PW'(pop);
        arr_we    = 1'b0;
        arr_waddr = head_addr;
        arr_wdata = head_data;
        unique case (state_q)
            StInit: begin
                arr_we    = 1'b1;
                arr_waddr = cnt_q;
                arr_wdata = '0;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(NREG - 1)) state_d = StRun;
            end
            StRun: begin
                arr_we = pop && (head_addr != '0);
                // A push alongside the clear still has to be drained before clearing.
                if (clear_req) begin
                    if (empty && !push) begin
                        state_d = StInit;
                        cnt_d   = '0;
                    end else begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                arr_we = pop && (head_addr != '0);
                if (wptr_q == rptr_d) begin
                    state_d = StInit;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StInit;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StInit;
            cnt_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end

    // Storage is intentionally unreset; INIT sweeps the array to zero.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wptr_q[IW-1:0]] <= wr_addr;
            fifo_data_q[wptr_q[IW-1:0]] <= wr_data;
        end
        if (arr_we) regs_q[arr_waddr] <= arr_wdata;
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] r;
`ifdef RF_WB_BYPASS_EN
        logic [IW-1:0]     idx;
`endif
        r = regs_q[a];
`ifdef RF_WB_BYPASS_EN
        // Walk oldest to youngest so the youngest matching entry wins.
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = rptr_q[IW-1:0] + IW'(i);
            if ((PW'(i) < pending_cnt) && (fifo_addr_q[idx] == a)) r = fifo_data_q[idx];
        end
`endif
        if ((state_q == StInit) || (a == '0)) r = '0;
        return r;
    endfunction

    always_comb begin
        Source1 = read_port(Address1);
        Source2 = read_port(Address2);
    end

endmodule

// File: tb/tb_rf_wb_writer.sv
// Directed self-checking bench for rf_wb_writer (default parameters); expectations track
// whether RF_WB_BYPASS_EN is defined for the build.
module tb_rf_wb_writer;

`ifdef RF_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        commit_en;
    logic        clear_req;
    logic [4:0]  Address1;
    logic [4:0]  Address2;
    logic [31:0] Source1;
    logic [31:0] Source2;
    logic        busy;
    logic [2:0]  pending_cnt;

    int total;
    int bad;

    rf_wb_writer #(
        .DATA_W(32),
        .ADDR_W(5),
        .DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .commit_en  (commit_en),
        .clear_req  (clear_req),
        .Address1   (Address1),
        .Address2   (Address2),
        .Source1    (Source1),
        .Source2    (Source2),
        .busy       (busy),
        .pending_cnt(pending_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b want=1", busy); end
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", wr_ready); end
        total++; if (pending_cnt !== 3'd0) begin bad++; $display("FAIL reset_pend got=%0d want=0", pending_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_init();
        for (int k = 0; k < 32; k++) begin
            Address1 = 5'(k);
            Address2 = 5'(31 - k);
            #1;
            total++; if (busy !== 1'b1 || wr_ready !== 1'b0) begin bad++;
                $display("FAIL init_busy k=%0d got busy=%b ready=%b want 1/0", k, busy, wr_ready); end
            total++; if (Source1 !== 32'h0 || Source2 !== 32'h0) begin bad++;
                $display("FAIL init_src k=%0d got %h/%h want 0/0", k, Source1, Source2); end
            step();
        end
        total++; if (busy !== 1'b0 || wr_ready !== 1'b1) begin bad++;
            $display("FAIL init_done got busy=%b ready=%b want 0/1", busy, wr_ready); end
        for (int a = 0; a < 32; a++) begin
            Address1 = 5'(a);
            Address2 = 5'(a);
            #1;
            total++; if (Source1 !== 32'h0 || Source2 !== 32'h0) begin bad++;
                $display("FAIL init_zero a=%0d got %h/%h want 0/0", a, Source1, Source2); end
        end
        step();
    endtask

    task automatic test_single();
        commit_en = 1'b1;
        wr_valid  = 1'b1;
        wr_addr   = 5'd3;
        wr_data   = 32'hDEADBEEF;
        Address1  = 5'd3;
        #1;
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b want=1", wr_ready); end
        step();
        wr_valid = 1'b0;
        #1;
        total++; if (pending_cnt !== 3'd1) begin bad++; $display("FAIL single_pend1 got=%0d want=1", pending_cnt); end
        total++; if (Source1 !== (BYP ? 32'hDEADBEEF : 32'h0)) begin bad++;
            $display("FAIL single_pre got=%h want=%h", Source1, BYP ? 32'hDEADBEEF : 32'h0); end
        step();
        total++; if (pending_cnt !== 3'd0) begin bad++; $display("FAIL single_pend0 got=%0d want=0", pending_cnt); end
        total++; if (Source1 !== 32'hDEADBEEF) begin bad++;
            $display("FAIL single_read got=%h want=deadbeef", Source1); end
    endtask

    task automatic test_fill();
        logic [31:0] exp;
        commit_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 5'(i + 1);
            wr_data  = 32'(17 * (i + 1));
            #1;
            total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL fill_ready i=%0d got=%b want=1", i, wr_ready); end
            step();
        end
        wr_valid = 1'b0;
        Address1 = 5'd1;
        #1;
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL fill_full got=%b want=0", wr_ready); end
        total++; if (pending_cnt !== 3'd4) begin bad++; $display("FAIL fill_pend got=%0d want=4", pending_cnt); end
        total++; if (Source1 !== (BYP ? 32'h11 : 32'h0)) begin bad++;
            $display("FAIL fill_pre got=%h want=%h", Source1, BYP ? 32'h11 : 32'h0); end
        commit_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            Address1 = 5'(i + 1);
            exp = 32'(17 * (i + 1));
            #1;
            total++; if (pending_cnt !== 3'(3 - i)) begin bad++;
                $display("FAIL drain_pend i=%0d got=%0d want=%0d", i, pending_cnt, 3 - i); end
            total++; if (Source1 !== exp) begin bad++;
                $display("FAIL drain_data i=%0d got=%h want=%h", i, Source1, exp); end
            if (i == 0) begin
                total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL drain_ready got=%b want=1", wr_ready); end
            end
        end
        commit_en = 1'b0;
        step();
    endtask

    task automatic test_same_addr();
        commit_en = 1'b0;
        wr_valid  = 1'b1;
        wr_addr   = 5'd7;
        wr_data   = 32'hA;
        step();
        wr_data = 32'hB;
        step();
        wr_valid = 1'b0;
        Address2 = 5'd7;
        #1;
        total++; if (pending_cnt !== 3'd2) begin bad++; $display("FAIL same_pend got=%0d want=2", pending_cnt); end
        total++; if (Source2 !== (BYP ? 32'hB : 32'h0)) begin bad++;
            $display("FAIL same_pre got=%h want=%h", Source2, BYP ? 32'hB : 32'h0); end
        commit_en = 1'b1;
        step();
        total++; if (Source2 !== (BYP ? 32'hB : 32'hA)) begin bad++;
            $display("FAIL same_mid got=%h want=%h", Source2, BYP ? 32'hB : 32'hA); end
        step();
        total++; if (Source2 !== 32'hB || pending_cnt !== 3'd0) begin bad++;
            $display("FAIL same_final got=%h pend=%0d want=b pend=0", Source2, pending_cnt); end
        commit_en = 1'b0;
    endtask

    task automatic test_addr0();
        commit_en = 1'b1;
        wr_valid  = 1'b1;
        wr_addr   = 5'd0;
        wr_data   = 32'hFFFFFFFF;
        Address1  = 5'd0;
        step();
        wr_valid = 1'b0;
        #1;
        total++; if (pending_cnt !== 3'd1 || Source1 !== 32'h0) begin bad++;
            $display("FAIL addr0_pre got pend=%0d src=%h want 1/0", pending_cnt, Source1); end
        step();
        total++; if (pending_cnt !== 3'd0 || Source1 !== 32'h0) begin bad++;
            $display("FAIL addr0_post got pend=%0d src=%h want 0/0", pending_cnt, Source1); end
        commit_en = 1'b0;
    endtask

    task automatic test_clear();
        commit_en = 1'b0;
        wr_valid  = 1'b1;
        wr_addr   = 5'd5;
        wr_data   = 32'h55;
        step();
        wr_addr = 5'd6;
        wr_data = 32'h66;
        step();
        wr_valid  = 1'b0;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        #1;
        total++; if (busy !== 1'b1 || wr_ready !== 1'b0 || pending_cnt !== 3'd2) begin bad++;
            $display("FAIL clr_drain got busy=%b ready=%b pend=%0d want 1/0/2", busy, wr_ready, pending_cnt); end
        wr_valid = 1'b1;
        wr_addr  = 5'd9;
        wr_data  = 32'h99;
        step();
        wr_valid = 1'b0;
        #1;
        total++; if (pending_cnt !== 3'd2 || wr_ready !== 1'b0) begin bad++;
            $display("FAIL clr_block got pend=%0d ready=%b want 2/0", pending_cnt, wr_ready); end
        commit_en = 1'b1;
        Address1  = 5'd5;
        step();
        total++; if (pending_cnt !== 3'd1 || busy !== 1'b1 || Source1 !== 32'h55) begin bad++;
            $display("FAIL clr_c1 got pend=%0d busy=%b src=%h want 1/1/55", pending_cnt, busy, Source1); end
        step();
        commit_en = 1'b0;
        total++; if (pending_cnt !== 3'd0) begin bad++; $display("FAIL clr_c2 got=%0d want=0", pending_cnt); end
        for (int k = 0; k < 32; k++) begin
            total++; if (busy !== 1'b1 || wr_ready !== 1'b0 || Source1 !== 32'h0) begin bad++;
                $display("FAIL clr_init k=%0d got busy=%b ready=%b src=%h want 1/0/0", k, busy, wr_ready, Source1); end
            step();
        end
        total++; if (busy !== 1'b0 || wr_ready !== 1'b1) begin bad++;
            $display("FAIL clr_done got busy=%b ready=%b want 0/1", busy, wr_ready); end
        for (int a = 1; a < 10; a++) begin
            Address1 = 5'(a);
            #1;
            total++; if (Source1 !== 32'h0) begin bad++; $display("FAIL clr_zero a=%0d got=%h want=0", a, Source1); end
        end
        step();
    endtask

    task automatic test_reset_mid();
        commit_en = 1'b0;
        wr_valid  = 1'b1;
        wr_addr   = 5'd2;
        wr_data   = 32'h22;
        step();
        wr_valid = 1'b0;
        total++; if (pending_cnt !== 3'd1) begin bad++; $display("FAIL rst_pre got=%0d want=1", pending_cnt); end
        rst_n = 1'b0;
        #1;
        total++; if (pending_cnt !== 3'd0 || busy !== 1'b1 || wr_ready !== 1'b0) begin bad++;
            $display("FAIL rst_mid got pend=%0d busy=%b ready=%b want 0/1/0", pending_cnt, busy, wr_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (32) @(negedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_init got busy=%b want=0", busy); end
        commit_en = 1'b1;
        Address1  = 5'd2;
        step();
        total++; if (pending_cnt !== 3'd0 || Source1 !== 32'h0) begin bad++;
            $display("FAIL rst_discard got pend=%0d src=%h want 0/0", pending_cnt, Source1); end
        commit_en = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        commit_en = 1'b0;
        clear_req = 1'b0;
        Address1  = '0;
        Address2  = '0;
        test_reset();
        test_init();
        test_single();
        test_fill();
        test_same_addr();
        test_addr0();
        test_clear();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
